// File: rtl/branch_predictor_if.sv
// ---------------------------------------------------------------------------
// branch_predictor_if
//   Fetch/execute-side bundle of the dynamic branch predictor.
//   master : pipeline side (drives fetch PC and execute-stage resolution)
//   slave  : predictor side (returns prediction and statistics)
//   Signals:
//     PC_F             fetch-stage PC to look up
//     Predicted        fetch PC is predicted taken
//     PC_Pre           predicted next fetch PC
//     Update_En        execute stage holds a resolved branch/jump
//     PC_E             PC of the resolved instruction
//     Execute          actual taken outcome
//     PC_ALU           actual computed target
//     Result           resolution code (00 wrong target, 01 correct,
//                      10 predicted T / actually NT, 11 predicted NT / actually T)
//     Branch_Count     resolved branches since reset
//     Mispredict_Count resolutions with Result != 01 since reset
// ---------------------------------------------------------------------------
interface branch_predictor_if #(
  parameter int WIDTH_DATA_LENGTH = 32,
  parameter int CNT_WIDTH         = 32
);
  logic [WIDTH_DATA_LENGTH-1:0] PC_F;
  logic                         Predicted;
  logic [WIDTH_DATA_LENGTH-1:0] PC_Pre;
  logic                         Update_En;
  logic [WIDTH_DATA_LENGTH-1:0] PC_E;
  logic                         Execute;
  logic [WIDTH_DATA_LENGTH-1:0] PC_ALU;
  logic [1:0]                   Result;
  logic [CNT_WIDTH-1:0]         Branch_Count;
  logic [CNT_WIDTH-1:0]         Mispredict_Count;

  modport master (
    output PC_F, Update_En, PC_E, Execute, PC_ALU, Result,
    input  Predicted, PC_Pre, Branch_Count, Mispredict_Count
  );

  modport slave (
    input  PC_F, Update_En, PC_E, Execute, PC_ALU, Result,
    output Predicted, PC_Pre, Branch_Count, Mispredict_Count
  );
endinterface

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//   Fetch-stage dynamic branch predictor: a direct-mapped table of 2-bit
//   saturating counters plus a branch target buffer, trained from the
//   execute-stage resolution, with branch/mispredict statistics.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bp     branch_predictor_if.slave (lookup, resolution and statistics)
//   Lookup is combinational from PC_F and registered state (no bypass of a
//   same-cycle update). Update happens on the rising edge when Update_En=1.
// ---------------------------------------------------------------------------
module branch_predictor #(
  parameter int WIDTH_DATA_LENGTH = 32,
  parameter int INDEX_BITS        = 6,
  parameter int CNT_WIDTH         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  branch_predictor_if.slave bp
);

  localparam int W       = WIDTH_DATA_LENGTH;
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = W - INDEX_BITS - 2;

  typedef logic [INDEX_BITS-1:0] idx_t;
  typedef logic [TAG_W-1:0]      tag_t;
  typedef logic [1:0]            ctr_t;

  typedef enum logic [1:0] {
    RES_WRONG_TARGET = 2'b00,
    RES_CORRECT      = 2'b01,
    RES_TAKEN_NT     = 2'b10,
    RES_NT_TAKEN     = 2'b11
  } result_e;

  localparam ctr_t CTR_RESET = 2'b01;  // weakly not-taken
  localparam ctr_t CTR_ALLOC = 2'b10;  // weakly taken, fresh entry

  // Table state
  logic [ENTRIES-1:0] valid_q;
  ctr_t               ctr_q    [ENTRIES];
  tag_t               tag_q    [ENTRIES];
  logic [W-1:0]       target_q [ENTRIES];

  logic [CNT_WIDTH-1:0] branch_cnt_q;
  logic [CNT_WIDTH-1:0] mispredict_cnt_q;

  // -------------------------------------------------------------------------
  // Lookup (fetch side)
  // -------------------------------------------------------------------------
  idx_t f_idx;
  tag_t f_tag;
  logic f_hit;

  assign f_idx = bp.PC_F[INDEX_BITS+1:2];
  assign f_tag = bp.PC_F[W-1:INDEX_BITS+2];
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

  // A miss is never predicted taken, whatever the counter at that slot says.
  assign bp.Predicted        = f_hit && ctr_q[f_idx][1];
  assign bp.PC_Pre           = bp.Predicted ? target_q[f_idx] : bp.PC_F + W'(4);
  assign bp.Branch_Count     = branch_cnt_q;
  assign bp.Mispredict_Count = mispredict_cnt_q;

  // -------------------------------------------------------------------------
  // Update decode (execute side)
  // -------------------------------------------------------------------------
  idx_t    e_idx;
  tag_t    e_tag;
  logic    e_hit;
  result_e e_res;
  logic    ctr_we;
  ctr_t    ctr_next;
  logic    btb_we;

  assign e_idx = bp.PC_E[INDEX_BITS+1:2];
  assign e_tag = bp.PC_E[W-1:INDEX_BITS+2];
  assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
  assign e_res = result_e'(bp.Result);

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    ctr_we   = 1'b0;
    ctr_next = ctr_q[e_idx];
    btb_we   = 1'b0;
    if (bp.Update_En) begin
      if (bp.Execute) begin
        ctr_we = 1'b1;
        if (!e_hit) begin
          // Allocation evicts whatever lived here; the new branch starts
          // weakly taken rather than inheriting the old counter.
          ctr_next = CTR_ALLOC;
          btb_we   = 1'b1;
        end else begin
          if (ctr_q[e_idx] != 2'b11) ctr_next = ctr_q[e_idx] + 2'b01;
          btb_we = (e_res == RES_WRONG_TARGET) || (e_res == RES_NT_TAKEN);
        end
      end else if (e_hit) begin
        // Not-taken on a miss must not disturb the resident branch.
        ctr_we = 1'b1;
        if (ctr_q[e_idx] != 2'b00) ctr_next = ctr_q[e_idx] - 2'b01;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Counter / valid state and statistics
  // -------------------------------------------------------------------------
  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q          <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_RESET;
    end else begin
      if (ctr_we) ctr_q[e_idx] <= ctr_next;
      if (btb_we) valid_q[e_idx] <= 1'b1;
      if (bp.Update_En) begin
        if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + 1'b1;
        if (e_res != RES_CORRECT && mispredict_cnt_q != '1)
          mispredict_cnt_q <= mispredict_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: tag/target storage is deliberately not reset; the cleared valid
  // bits hide its contents, so resetting it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (rst_n && btb_we) begin
      tag_q[e_idx]    <= e_tag;
      target_q[e_idx] <= bp.PC_ALU;
    end
  end

  // Instruction alignment bits carry no information for the predictor.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{bp.PC_F[1:0], bp.PC_E[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
  localparam int W  = 32;
  localparam int IB = 6;
  localparam int CW = 32;
  localparam int N  = 64;

  logic clk = 1'b0;
  logic rst_n;

  branch_predictor_if #(.WIDTH_DATA_LENGTH(W), .CNT_WIDTH(CW)) bp ();

  branch_predictor #(.WIDTH_DATA_LENGTH(W), .INDEX_BITS(IB), .CNT_WIDTH(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bp   (bp)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: counters as plain integers 0..3, one record per slot.
  int          m_ctr   [N];
  bit          m_valid [N];
  int unsigned m_tag   [N];
  logic [31:0] m_tgt   [N];
  int unsigned m_bc, m_mc;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    return m_valid[slot(pc)] && (m_tag[slot(pc)] == (pc >> 8));
  endfunction

  function automatic bit model_pred(input logic [31:0] pc);
    return model_hit(pc) && (m_ctr[slot(pc)] >= 2);
  endfunction

  function automatic logic [31:0] model_pc_pre(input logic [31:0] pc);
    logic [31:0] nxt;
    nxt = pc + 32'd4;
    return model_pred(pc) ? m_tgt[slot(pc)] : nxt;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_ctr[i] = 1;
      m_valid[i] = 1'b0;
    end
    m_bc = 0;
    m_mc = 0;
  endtask

  task automatic model_update(input logic [31:0] pc, input bit exe,
                              input logic [31:0] alu, input logic [1:0] res);
    int s;
    s = slot(pc);
    if (model_hit(pc)) begin
      if (exe) begin
        m_ctr[s] = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
        if (res == 2'b11 || res == 2'b00) m_tgt[s] = alu;
      end else begin
        m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
      end
    end else if (exe) begin
      m_valid[s] = 1'b1;
      m_tag[s]   = pc >> 8;
      m_tgt[s]   = alu;
      m_ctr[s]   = 2;
    end
    m_bc++;
    if (res != 2'b01) m_mc++;
  endtask

  // One resolved branch applied on the next rising edge; returns at edge+1.
  task automatic drive_update(input logic [31:0] pc, input bit exe,
                              input logic [31:0] alu, input logic [1:0] res);
    bp.Update_En = 1'b1;
    bp.PC_E      = pc;
    bp.Execute   = exe;
    bp.PC_ALU    = alu;
    bp.Result    = res;
    @(posedge clk);
    #1;
    bp.Update_En = 1'b0;
    model_update(pc, exe, alu, res);
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bp.PC_F      = 32'h100;
    bp.Update_En = 1'b0;
    bp.PC_E      = '0;
    bp.Execute   = 1'b0;
    bp.PC_ALU    = '0;
    bp.Result    = 2'b01;
    model_reset();
    #1;
    n_cmp++; if (bp.Predicted !== 1'b0) begin n_err++; $display("FAIL reset_pred: got %b want 0", bp.Predicted); end
    n_cmp++; if (bp.PC_Pre !== 32'h104) begin n_err++; $display("FAIL reset_pc_pre: got %h want 00000104", bp.PC_Pre); end
    n_cmp++; if (bp.Branch_Count !== 32'd0) begin n_err++; $display("FAIL reset_bc: got %0d want 0", bp.Branch_Count); end
    n_cmp++; if (bp.Mispredict_Count !== 32'd0) begin n_err++; $display("FAIL reset_mc: got %0d want 0", bp.Mispredict_Count); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_allocate();
    drive_update(32'h100, 1'b1, 32'h200, 2'b11);
    bp.PC_F = 32'h100;
    #1;
    n_cmp++; if (bp.Predicted !== 1'b1) begin n_err++; $display("FAIL alloc_pred: got %b want 1", bp.Predicted); end
    n_cmp++; if (bp.PC_Pre !== 32'h200) begin n_err++; $display("FAIL alloc_pc_pre: got %h want 00000200", bp.PC_Pre); end
    n_cmp++; if (bp.Branch_Count !== 32'd1) begin n_err++; $display("FAIL alloc_bc: got %0d want 1", bp.Branch_Count); end
    n_cmp++; if (bp.Mispredict_Count !== 32'd1) begin n_err++; $display("FAIL alloc_mc: got %0d want 1", bp.Mispredict_Count); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) drive_update(32'h100, 1'b1, 32'h999, 2'b01);
    #1;
    n_cmp++; if (bp.PC_Pre !== 32'h200) begin n_err++; $display("FAIL sat_hi_pc_pre: got %h want 00000200", bp.PC_Pre); end
    for (int i = 0; i < 2; i++) drive_update(32'h100, 1'b0, 32'h0, 2'b10);
    #1;
    n_cmp++; if (bp.Predicted !== 1'b0) begin n_err++; $display("FAIL sat_lo_pred: got %b want 0", bp.Predicted); end
    n_cmp++; if (bp.PC_Pre !== 32'h104) begin n_err++; $display("FAIL sat_lo_pc_pre: got %h want 00000104", bp.PC_Pre); end
    n_cmp++; if (bp.Mispredict_Count !== 32'd3) begin n_err++; $display("FAIL sat_mc: got %0d want 3", bp.Mispredict_Count); end
    n_cmp++; if (bp.Branch_Count !== 32'd6) begin n_err++; $display("FAIL sat_bc: got %0d want 6", bp.Branch_Count); end
  endtask

  task automatic test_alias();
    for (int i = 0; i < 2; i++) drive_update(32'h100, 1'b1, 32'h999, 2'b01);
    drive_update(32'h200, 1'b0, 32'h0, 2'b10);
    bp.PC_F = 32'h100;
    #1;
    n_cmp++; if (bp.PC_Pre !== 32'h200) begin n_err++; $display("FAIL alias_keep: got %h want 00000200", bp.PC_Pre); end
    drive_update(32'h200, 1'b1, 32'h300, 2'b11);
    bp.PC_F = 32'h100;
    #1;
    n_cmp++; if (bp.PC_Pre !== 32'h104) begin n_err++; $display("FAIL alias_evict: got %h want 00000104", bp.PC_Pre); end
    bp.PC_F = 32'h200;
    #1;
    n_cmp++; if (bp.Predicted !== 1'b1) begin n_err++; $display("FAIL alias_new_pred: got %b want 1", bp.Predicted); end
    n_cmp++; if (bp.PC_Pre !== 32'h300) begin n_err++; $display("FAIL alias_new_pc_pre: got %h want 00000300", bp.PC_Pre); end
  endtask

  task automatic test_wrong_target();
    drive_update(32'h100, 1'b1, 32'h200, 2'b11);
    bp.PC_F      = 32'h100;
    bp.Update_En = 1'b1;
    bp.PC_E      = 32'h100;
    bp.Execute   = 1'b1;
    bp.PC_ALU    = 32'h240;
    bp.Result    = 2'b00;
    #1;
    n_cmp++; if (bp.PC_Pre !== 32'h200) begin n_err++; $display("FAIL wt_same_cycle: got %h want 00000200", bp.PC_Pre); end
    @(posedge clk);
    #1;
    bp.Update_En = 1'b0;
    model_update(32'h100, 1'b1, 32'h240, 2'b00);
    #1;
    n_cmp++; if (bp.PC_Pre !== 32'h240) begin n_err++; $display("FAIL wt_refresh: got %h want 00000240", bp.PC_Pre); end
    n_cmp++; if (bp.Mispredict_Count !== 32'd7) begin n_err++; $display("FAIL wt_mc: got %0d want 7", bp.Mispredict_Count); end
  endtask

  task automatic test_wrap();
    bp.PC_F = 32'hFFFF_FFFC;
    #1;
    n_cmp++; if (bp.Predicted !== 1'b0) begin n_err++; $display("FAIL wrap_pred: got %b want 0", bp.Predicted); end
    n_cmp++; if (bp.PC_Pre !== 32'h0) begin n_err++; $display("FAIL wrap_pc_pre: got %h want 00000000", bp.PC_Pre); end
  endtask

  function automatic logic [31:0] pool_pc();
    logic [31:0] tags [4];
    tags[0] = 32'h000001; tags[1] = 32'h000002; tags[2] = 32'hABCDEF; tags[3] = 32'hFFFFFF;
    return (tags[$urandom_range(0, 3)] << 8) | (32'($urandom_range(0, 7)) << 2);
  endfunction

  task automatic test_random();
    logic [31:0] pf, pe, alu;
    bit en, exe;
    logic [1:0] res;
    for (int i = 0; i < 400; i++) begin
      pf  = pool_pc();
      pe  = ($urandom_range(0, 3) == 0) ? pf : pool_pc();
      en  = $urandom_range(0, 3) != 0;
      exe = $urandom_range(0, 1);
      alu = $urandom & 32'hFFFF_FFFC;
      res = 2'($urandom_range(0, 3));
      bp.PC_F = pf; bp.Update_En = en; bp.PC_E = pe;
      bp.Execute = exe; bp.PC_ALU = alu; bp.Result = res;
      #1;
      n_cmp++; if (bp.Predicted !== model_pred(pf)) begin n_err++; $display("FAIL rnd_pred[%0d]: pc %h got %b want %b", i, pf, bp.Predicted, model_pred(pf)); end
      n_cmp++; if (bp.PC_Pre !== model_pc_pre(pf)) begin n_err++; $display("FAIL rnd_pc_pre[%0d]: pc %h got %h want %h", i, pf, bp.PC_Pre, model_pc_pre(pf)); end
      n_cmp++; if (bp.Branch_Count !== m_bc) begin n_err++; $display("FAIL rnd_bc[%0d]: got %0d want %0d", i, bp.Branch_Count, m_bc); end
      n_cmp++; if (bp.Mispredict_Count !== m_mc) begin n_err++; $display("FAIL rnd_mc[%0d]: got %0d want %0d", i, bp.Mispredict_Count, m_mc); end
      @(posedge clk);
      #1;
      if (en) model_update(pe, exe, alu, res);
    end
    bp.Update_En = 1'b0;
  endtask

  task automatic test_async_reset();
    // Three taken updates guarantee a strong-enough counter from any state.
    for (int i = 0; i < 3; i++) drive_update(32'h100, 1'b1, 32'h200, 2'b11);
    bp.PC_F = 32'h100;
    #1;
    n_cmp++; if (bp.PC_Pre !== 32'h200) begin n_err++; $display("FAIL arst_pre: got %h want 00000200", bp.PC_Pre); end
    bp.Update_En = 1'b1; bp.PC_E = 32'h100; bp.Execute = 1'b1;
    bp.PC_ALU = 32'h500; bp.Result = 2'b00;
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bp.Predicted !== 1'b0) begin n_err++; $display("FAIL arst_pred: got %b want 0", bp.Predicted); end
    n_cmp++; if (bp.PC_Pre !== 32'h104) begin n_err++; $display("FAIL arst_pc_pre: got %h want 00000104", bp.PC_Pre); end
    n_cmp++; if (bp.Branch_Count !== 32'd0) begin n_err++; $display("FAIL arst_bc: got %0d want 0", bp.Branch_Count); end
    n_cmp++; if (bp.Mispredict_Count !== 32'd0) begin n_err++; $display("FAIL arst_mc: got %0d want 0", bp.Mispredict_Count); end
    @(posedge clk);
    #1;
    bp.Update_En = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    n_cmp++; if (bp.PC_Pre !== 32'h104) begin n_err++; $display("FAIL arst_after_pc_pre: got %h want 00000104", bp.PC_Pre); end
    n_cmp++; if (bp.Branch_Count !== 32'd0) begin n_err++; $display("FAIL arst_after_bc: got %0d want 0", bp.Branch_Count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_allocate();
    test_saturation();
    test_alias();
    test_wrong_target();
    test_wrap();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
